// File: rtl/disp_scan_ctrl.sv
// Multiplexed display scanner: walks a digit index over the enabled digits,
// one slot per PRESCALE cycles, with a leading blank interval in each slot.
// All outputs are registered and change together with the state.
module disp_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int IDX_W            = 2,
  parameter int PRESCALE         = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [NUM_DIGITS-1:0] DIGIT_MASK,
  output logic [IDX_W-1:0]      DIGIT_SEL,
  output logic [NUM_DIGITS-1:0] ANODE,
  output logic                  BLANK,
  output logic                  SCAN_TICK,
  output logic                  FRAME_START
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  // With no blank interval a slot opens directly in the show phase.
  localparam logic [1:0] S_START = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  blank_q, blank_d;
  logic                  tick_q, tick_d;
  logic                  frame_q, frame_d;

  logic [IDX_W-1:0]      low_idx, nxt_idx;
  logic                  nxt_found;
  logic                  start;
  logic [IDX_W-1:0]      start_idx;

  // Anode pattern for a digit index, in the configured polarity.
  function automatic logic [NUM_DIGITS-1:0] anode_of(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    for (int i = 0; i < NUM_DIGITS; i++) oh[i] = (IDX_W'(i) == idx);
    return ANODE_ACTIVE_LOW ? ~oh : oh;
  endfunction

  // Lowest enabled digit, and the next enabled digit strictly above the current one.
  always_comb begin
    low_idx   = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (DIGIT_MASK[i]) low_idx = IDX_W'(i);
      if (DIGIT_MASK[i] && (i > int'(sel_q))) begin
        nxt_idx   = IDX_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  // Scan sequencing: enable/idle handling, slot counting, digit advance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    anode_d   = anode_q;
    blank_d   = blank_q;
    tick_d    = 1'b0;
    frame_d   = 1'b0;
    start     = 1'b0;
    start_idx = sel_q;

    if (!EN || ((state_q != S_IDLE) && (cnt_q == CNT_LAST) && (DIGIT_MASK == '0))) begin
      // Disabled, or mask emptied at a slot boundary: park with DIGIT_SEL held.
      state_d = S_IDLE;
      cnt_d   = '0;
      anode_d = ANODE_OFF;
      blank_d = 1'b1;
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (DIGIT_MASK != '0) begin
        start     = 1'b1;
        start_idx = low_idx;
        frame_d   = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      start     = 1'b1;
      start_idx = nxt_found ? nxt_idx : low_idx;
      frame_d   = !nxt_found;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if ((BLANK_CYCLES != 0) && (cnt_q == CNT_BLK_LAST)) begin
        state_d = S_SHOW;
        anode_d = anode_of(sel_q);
        blank_d = 1'b0;
      end
    end

    if (start) begin
      state_d = S_START;
      cnt_d   = '0;
      sel_d   = start_idx;
      tick_d  = 1'b1;
      anode_d = (BLANK_CYCLES == 0) ? anode_of(start_idx) : ANODE_OFF;
      blank_d = (BLANK_CYCLES != 0);
    end
  end

  // State and output registers; reset forces anodes off and strobes low at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      anode_q <= ANODE_OFF;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign DIGIT_SEL   = sel_q;
  assign ANODE       = anode_q;
  assign BLANK       = blank_q;
  assign SCAN_TICK   = tick_q;
  assign FRAME_START = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios with literal checks, then a
// randomized phase; a slot-level model is compared on every falling edge.
module tb_disp_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int BC = 2;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         EN;
  logic [N-1:0] DIGIT_MASK;
  logic [1:0]   DIGIT_SEL;
  logic [N-1:0] ANODE;
  logic         BLANK, SCAN_TICK, FRAME_START;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  disp_scan_ctrl #(
    .NUM_DIGITS(N), .IDX_W(2), .PRESCALE(P), .BLANK_CYCLES(BC), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DIGIT_MASK(DIGIT_MASK),
    .DIGIT_SEL(DIGIT_SEL), .ANODE(ANODE), .BLANK(BLANK),
    .SCAN_TICK(SCAN_TICK), .FRAME_START(FRAME_START)
  );

  always #5 CLK = ~CLK;

  // Slot-level model: scanning or not, position inside the slot, current digit, strobes.
  bit m_act = 0;
  int m_pos = 0;
  int m_dig = 0;
  bit m_tick = 0;
  bit m_frame = 0;

  function automatic int lowest(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int above(input logic [N-1:0] m, input int d);
    for (int i = d + 1; i < N; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_act = 0; m_pos = 0; m_dig = 0; m_tick = 0; m_frame = 0;
    end else begin
      m_tick = 0; m_frame = 0;
      if (!EN) begin
        m_act = 0; m_pos = 0;
      end else if (!m_act) begin
        m_pos = 0;
        if (DIGIT_MASK != 0) begin
          m_act = 1; m_dig = lowest(DIGIT_MASK); m_tick = 1; m_frame = 1;
        end
      end else if (m_pos == P - 1) begin
        m_pos = 0;
        if (DIGIT_MASK == 0) m_act = 0;
        else begin
          int nx;
          nx = above(DIGIT_MASK, m_dig);
          m_tick = 1;
          if (nx < 0) begin m_dig = lowest(DIGIT_MASK); m_frame = 1; end
          else m_dig = nx;
        end
      end else m_pos++;
    end
  end

  function automatic logic [N-1:0] m_anode();
    logic [N-1:0] a;
    a = '1;
    if (m_act && m_pos >= BC) a[m_dig] = 1'b0;
    return a;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [8:0] ex, ac;
      ex = {2'(m_dig), m_anode(), !(m_act && m_pos >= BC), m_tick, m_frame};
      ac = {DIGIT_SEL, ANODE, BLANK, SCAN_TICK, FRAME_START};
      n_tests++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL model t=%0t: got sel=%0d anode=%b blank=%b tick=%b frame=%b, expected %b_%b_%b_%b_%b",
                 $time, DIGIT_SEL, ANODE, BLANK, SCAN_TICK, FRAME_START,
                 ex[8:7], ex[6:3], ex[2], ex[1], ex[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; DIGIT_MASK = '0;
    step(2);
    chk_en = 1'b1;
    chk("rst_sel", 32'(DIGIT_SEL), 0);
    chk("rst_anode", 32'(ANODE), 32'hF);
    chk("rst_blank", 32'(BLANK), 1);
    chk("rst_strobes", 32'({SCAN_TICK, FRAME_START}), 0);
    RST_N = 1'b1;
    step(1);

    // 1: full mask
    EN = 1'b1; DIGIT_MASK = 4'b1111;
    step(1);
    chk("s1_first_sel", 32'(DIGIT_SEL), 0);
    chk("s1_first_strobes", 32'({SCAN_TICK, FRAME_START}), 32'b11);
    chk("s1_first_anode", 32'(ANODE), 32'hF);
    step(2);
    chk("s1_show_anode", 32'(ANODE), 32'hE);
    chk("s1_show_blank", 32'(BLANK), 0);
    step(6);
    chk("s1_d1_sel", 32'(DIGIT_SEL), 1);
    chk("s1_d1_strobes", 32'({SCAN_TICK, FRAME_START}), 32'b10);
    step(24);
    chk("s1_wrap_sel", 32'(DIGIT_SEL), 0);
    chk("s1_wrap_frame", 32'(FRAME_START), 1);

    // 2: mask 0101
    DIGIT_MASK = 4'b0101;
    step(8);
    chk("s2_sel2", 32'(DIGIT_SEL), 2);
    chk("s2_noframe", 32'(FRAME_START), 0);
    step(2);
    chk("s2_anode", 32'(ANODE), 32'hB);
    step(6);
    chk("s2_wrap", 32'({DIGIT_SEL, FRAME_START}), 32'b001);

    // 3: single digit
    DIGIT_MASK = 4'b0100;
    step(8);
    chk("s3_enter_sel", 32'(DIGIT_SEL), 2);
    chk("s3_enter_frame", 32'(FRAME_START), 0);
    step(8);
    chk("s3_single_strobes", 32'({DIGIT_SEL, SCAN_TICK, FRAME_START}), 32'b1011);
    step(2);
    chk("s3_anode", 32'(ANODE), 32'hB);

    // 4: mask cleared mid-slot on digit 1
    DIGIT_MASK = 4'b1111;
    step(6);
    chk("s4_sel3", 32'(DIGIT_SEL), 3);
    step(16);
    chk("s4_sel1", 32'(DIGIT_SEL), 1);
    step(3);
    DIGIT_MASK = 4'b0000;
    step(4);
    chk("s4_finish_anode", 32'(ANODE), 32'hD);
    step(1);
    chk("s4_idle_anode", 32'(ANODE), 32'hF);
    chk("s4_idle_blank_strobes", 32'({BLANK, SCAN_TICK, FRAME_START}), 32'b100);
    chk("s4_idle_sel", 32'(DIGIT_SEL), 1);
    step(5);

    // 5: EN dropped at counter 5 on digit 2
    DIGIT_MASK = 4'b1111;
    step(1);
    chk("s5_restart_sel", 32'(DIGIT_SEL), 0);
    step(21);
    chk("s5_cnt5_anode", 32'(ANODE), 32'hB);
    EN = 1'b0;
    step(1);
    chk("s5_off_anode", 32'(ANODE), 32'hF);
    chk("s5_off_sel", 32'(DIGIT_SEL), 2);
    chk("s5_off_strobes", 32'({SCAN_TICK, FRAME_START}), 0);
    step(3);
    EN = 1'b1;
    step(1);
    chk("s5_reen", 32'({DIGIT_SEL, SCAN_TICK, FRAME_START}), 32'b0011);

    // 6: async reset mid-SHOW on digit 3
    step(27);
    chk("s6_pre_anode", 32'(ANODE), 32'h7);
    #2 RST_N = 1'b0;
    #1;
    chk("s6_async_anode", 32'(ANODE), 32'hF);
    chk("s6_async_sel", 32'(DIGIT_SEL), 0);
    chk("s6_async_strobes", 32'({SCAN_TICK, FRAME_START}), 0);
    step(1);
    chk("s6_held_strobes", 32'({SCAN_TICK, FRAME_START, BLANK}), 32'b001);
    RST_N = 1'b1;
    step(1);
    chk("s6_resume", 32'({DIGIT_SEL, SCAN_TICK, FRAME_START}), 32'b0011);
    step(8);
    chk("s6_next", 32'(DIGIT_SEL), 1);

    // Randomized phase: mask, enable and reset disturbances at arbitrary cycles.
    for (int c = 0; c < 1500; c++) begin
      int r;
      step(1);
      if (!RST_N) RST_N = 1'b1;
      r = $urandom_range(0, 199);
      if (r < 12) DIGIT_MASK = 4'($urandom_range(0, 15));
      else if (r < 15) EN = ~EN;
      else if (r == 15) RST_N = 1'b0;
      else if (r < 20 && !EN) EN = 1'b1;
    end
    RST_N = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
